// File: rtl/imem_fetch_unit_if.sv
// Load/fetch bus of the instruction memory fetch unit.
interface imem_fetch_unit_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ISSUE_W = 2
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    logic                      load_valid;
    logic [DATA_W-1:0]         load_data;
    logic                      load_last;
    logic                      load_ready;
    logic                      start;
    logic                      fetch_stall;
    logic                      redirect_valid;
    logic [ADDR_W-1:0]         redirect_pc;
    logic                      fetch_valid;
    logic [ADDR_W-1:0]         fetch_pc;
    logic [ISSUE_W*DATA_W-1:0] fetch_instr;
    logic [ISSUE_W-1:0]        fetch_slot_valid;
    logic [LEN_W-1:0]          prog_len;
    logic                      done;

    // Loader / decode side
    modport master (
        output load_valid, load_data, load_last, start, fetch_stall,
               redirect_valid, redirect_pc,
        input  load_ready, fetch_valid, fetch_pc, fetch_instr,
               fetch_slot_valid, prog_len, done
    );

    // Fetch unit side
    modport slave (
        input  load_valid, load_data, load_last, start, fetch_stall,
               redirect_valid, redirect_pc,
        output load_ready, fetch_valid, fetch_pc, fetch_instr,
               fetch_slot_valid, prog_len, done
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with sequential load port and multi-issue fetch port.
module imem_fetch_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ISSUE_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_unit_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {LOAD, LOADED, FETCH, DONE} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         mem [DEPTH];
    logic [ADDR_W-1:0]         wptr;
    logic [ADDR_W-1:0]         pc;
    logic                      last_out;

    logic [ADDR_W-1:0]         base_c;
    logic [LEN_W-1:0]          next_base_c;
    logic [LEN_W-1:0]          slot_c;
    logic                      last_grp_c;
    logic                      load_fire_c;
    logic                      accept_c;
    logic [ISSUE_W-1:0]        mask_c;
    logic [ISSUE_W*DATA_W-1:0] grp_c;

    // Group addressed by pc: aligned base, slot mask and masked read data
    always_comb begin
        base_c      = pc & ~ADDR_W'(ISSUE_W - 1);
        next_base_c = LEN_W'(base_c) + LEN_W'(ISSUE_W);
        last_grp_c  = next_base_c >= bus.prog_len;
        load_fire_c = (state == LOAD) && bus.load_valid && bus.load_ready;
        accept_c    = !bus.fetch_valid || !bus.fetch_stall;
        slot_c      = '0;
        mask_c      = '0;
        grp_c       = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            slot_c = LEN_W'(base_c) + LEN_W'(i);
            if (slot_c >= LEN_W'(pc) && slot_c < bus.prog_len) begin
                mask_c[i]                  = 1'b1;
                grp_c[i*DATA_W +: DATA_W]  = mem[base_c + ADDR_W'(i)];
            end
        end
    end

    // Program storage; contents survive reset
    always_ff @(posedge clk) begin
        if (load_fire_c) begin
            mem[wptr] <= bus.load_data;
        end
    end

    // Control FSM with registered outputs; last_out marks the final group on the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= LOAD;
            wptr                 <= '0;
            pc                   <= '0;
            last_out             <= 1'b0;
            bus.load_ready       <= 1'b1;
            bus.fetch_valid      <= 1'b0;
            bus.fetch_pc         <= '0;
            bus.fetch_instr      <= '0;
            bus.fetch_slot_valid <= '0;
            bus.prog_len         <= '0;
            bus.done             <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire_c) begin
                        wptr <= wptr + 1'b1;
                        if (bus.load_last || wptr == ADDR_W'(DEPTH - 1)) begin
                            bus.prog_len   <= LEN_W'(wptr) + 1'b1;
                            bus.load_ready <= 1'b0;
                            state          <= LOADED;
                        end
                    end
                end
                LOADED: begin
                    if (bus.start) begin
                        pc       <= '0;
                        last_out <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        bus.fetch_valid <= 1'b0;
                        last_out        <= 1'b0;
                        pc              <= bus.redirect_pc;
                        if (LEN_W'(bus.redirect_pc) >= bus.prog_len) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (accept_c) begin
                        if (last_out) begin
                            bus.fetch_valid <= 1'b0;
                            bus.done        <= 1'b1;
                            last_out        <= 1'b0;
                            state           <= DONE;
                        end else begin
                            bus.fetch_valid      <= 1'b1;
                            bus.fetch_pc         <= base_c;
                            bus.fetch_instr      <= grp_c;
                            bus.fetch_slot_valid <= mask_c;
                            last_out             <= last_grp_c;
                            if (!last_grp_c) begin
                                pc <= next_base_c[ADDR_W-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        bus.done <= 1'b0;
                        pc       <= '0;
                        last_out <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit against a group-list reference model.
module tb_imem_fetch_unit;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 2;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = AW + 1;

    logic clk;
    logic rst;

    imem_fetch_unit_if #(.DATA_W(DW), .DEPTH(DEPTH), .ISSUE_W(IW)) bus ();

    imem_fetch_unit #(.DATA_W(DW), .DEPTH(DEPTH), .ISSUE_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run;
    int n_fail;
    logic [DW-1:0] model_mem [DEPTH];
    int model_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid     = 1'b0;
        bus.load_data      = '0;
        bus.load_last      = 1'b0;
        bus.start          = 1'b0;
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // Streams model_mem[0..n-1], with random idle gaps
    task automatic load_words(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.load_valid = 1'b0;
                step();
            end
            n_run++;
            if (bus.load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready_word%0d: got %b expected 1", i, bus.load_ready);
            end
            bus.load_valid = 1'b1;
            bus.load_data  = model_mem[AW'(i)];
            bus.load_last  = use_last && (i == n - 1);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_len = n;
        n_run++;
        if (bus.load_ready !== 1'b0 || bus.prog_len !== LW'(n)) begin
            n_fail++;
            $display("FAIL load_end: load_ready=%b prog_len=%0d expected 0 and %0d",
                     bus.load_ready, bus.prog_len, n);
        end
    endtask

    // Pulse start; first group must appear two cycles later
    task automatic begin_fetch();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_run++;
        if (bus.fetch_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_gap: fetch_valid=%b done=%b expected 0 0",
                     bus.fetch_valid, bus.done);
        end
        step();
    endtask

    // Expects the first group on the outputs now; walks all groups from first_pc to the end
    task automatic consume(input int first_pc, input int stall_base, input int stall_len,
                           input bit rand_stall);
        int qb[$];
        logic [IW-1:0] qm[$];
        logic [IW*DW-1:0] qd[$];
        int p;
        int base;
        int ns;
        p    = first_pc;
        base = p - (p % IW);
        while (base < model_len) begin
            logic [IW-1:0]    m;
            logic [IW*DW-1:0] d;
            m = '0;
            d = '0;
            for (int i = 0; i < IW; i++) begin
                int a;
                a = base + i;
                if (a >= p && a < model_len) begin
                    m[i]            = 1'b1;
                    d[i*DW +: DW]   = model_mem[AW'(a)];
                end
            end
            qb.push_back(base);
            qm.push_back(m);
            qd.push_back(d);
            base = base + IW;
            p    = base;
        end
        for (int k = 0; k < qb.size(); k++) begin
            if (qb[k] == stall_base) ns = stall_len;
            else if (rand_stall)     ns = $urandom_range(0, 2);
            else                     ns = 0;
            for (int s = 0; s <= ns; s++) begin
                n_run++;
                if (bus.fetch_valid !== 1'b1 || bus.done !== 1'b0 ||
                    bus.fetch_pc !== AW'(qb[k]) || bus.fetch_slot_valid !== qm[k] ||
                    bus.fetch_instr !== qd[k]) begin
                    n_fail++;
                    $display("FAIL group_pc%0d_hold%0d: got v=%b done=%b pc=%0d mask=%b data=%h expected v=1 done=0 pc=%0d mask=%b data=%h",
                             qb[k], s, bus.fetch_valid, bus.done, bus.fetch_pc,
                             bus.fetch_slot_valid, bus.fetch_instr, qb[k], qm[k], qd[k]);
                end
                bus.fetch_stall = (s < ns);
                step();
            end
        end
        bus.fetch_stall = 1'b0;
        n_run++;
        if (bus.done !== 1'b1 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_after_last: done=%b fetch_valid=%b expected 1 0",
                     bus.done, bus.fetch_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_run++;
        if (bus.load_ready !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.fetch_pc !== '0 ||
            bus.fetch_slot_valid !== '0 || bus.fetch_instr !== '0 || bus.prog_len !== '0 ||
            bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b v=%b pc=%0d mask=%b data=%h len=%0d done=%b expected 1 0 0 0 0 0 0",
                     bus.load_ready, bus.fetch_valid, bus.fetch_pc, bus.fetch_slot_valid,
                     bus.fetch_instr, bus.prog_len, bus.done);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        n_run++;
        if (bus.load_ready !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_load: ready=%b v=%b done=%b expected 1 0 0",
                     bus.load_ready, bus.fetch_valid, bus.done);
        end
    endtask

    task automatic test_load_seq();
        apply_reset();
        for (int i = 0; i < 5; i++) model_mem[AW'(i)] = 32'hA0 + DW'(i);
        load_words(5, 1'b1);
        begin_fetch();
        n_run++;
        if (bus.fetch_instr !== {32'hA1, 32'hA0} || bus.fetch_slot_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL first_group_const: data=%h mask=%b expected 000000a1000000a0 11",
                     bus.fetch_instr, bus.fetch_slot_valid);
        end
        consume(0, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        begin_fetch();
        consume(0, 2, 3, 1'b0);
    endtask

    task automatic test_redirect_odd();
        begin_fetch();
        bus.fetch_stall    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(3);
        step();
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        n_run++;
        if (bus.fetch_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_bubble: v=%b done=%b expected 0 0", bus.fetch_valid, bus.done);
        end
        step();
        consume(3, -1, 0, 1'b0);
    endtask

    task automatic test_redirect_out_of_range();
        begin_fetch();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(7);
        step();
        bus.redirect_valid = 1'b0;
        n_run++;
        if (bus.done !== 1'b1 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_oor: done=%b v=%b expected 1 0", bus.done, bus.fetch_valid);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_run++;
            if (bus.fetch_valid !== 1'b0 || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_quiet_c%0d: v=%b done=%b expected 0 1", c, bus.fetch_valid, bus.done);
            end
        end
    endtask

    task automatic test_full_depth();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[AW'(i)] = $urandom;
        load_words(DEPTH, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_BEEF;
        step();
        bus.load_valid = 1'b0;
        n_run++;
        if (bus.load_ready !== 1'b0 || bus.prog_len !== LW'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_no_extra: ready=%b len=%0d expected 0 %0d",
                     bus.load_ready, bus.prog_len, DEPTH);
        end
        begin_fetch();
        consume(0, -1, 0, 1'b1);
        begin_fetch();
        consume(0, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        begin_fetch();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_run++;
        if (bus.load_ready !== 1'b1 || bus.prog_len !== '0 || bus.fetch_valid !== 1'b0 ||
            bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: ready=%b len=%0d v=%b done=%b expected 1 0 0 0",
                     bus.load_ready, bus.prog_len, bus.fetch_valid, bus.done);
        end
        for (int i = 0; i < 3; i++) model_mem[AW'(i)] = $urandom;
        load_words(3, 1'b1);
        begin_fetch();
        consume(0, -1, 0, 1'b1);
    endtask

    task automatic test_random();
        int len;
        int tgt;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) model_mem[AW'(i)] = $urandom;
            load_words(len, (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
            begin_fetch();
            if ($urandom_range(0, 1) == 1) begin
                tgt = $urandom_range(0, len + 1);
                if (tgt > DEPTH - 1) tgt = DEPTH - 1;
                bus.fetch_stall    = 1'($urandom_range(0, 1));
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = AW'(tgt);
                step();
                bus.fetch_stall    = 1'b0;
                bus.redirect_valid = 1'b0;
                n_run++;
                if (bus.fetch_valid !== 1'b0 || bus.done !== (tgt >= len)) begin
                    n_fail++;
                    $display("FAIL rand_redirect_it%0d: v=%b done=%b expected 0 %b",
                             it, bus.fetch_valid, bus.done, (tgt >= len));
                end
                if (tgt < len) begin
                    step();
                    consume(tgt, -1, 0, 1'b1);
                end
            end else begin
                consume(0, -1, 0, 1'b1);
            end
            begin_fetch();
            consume(0, -1, 0, 1'b1);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_load_seq();
        test_stall();
        test_redirect_odd();
        test_redirect_out_of_range();
        test_full_depth();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised instruction memory with a sequential load port and a multi-issue fetch port. A loader streams a program in over a valid/ready handshake. The fetch side then delivers aligned groups of `ISSUE_W` instructions per cycle to the decode stage, with per-slot valid masking, stall hold, branch redirect and end-of-program detection. It replaces the single-issue instruction buffer in the front end.

## Interface
- `DATA_W`, 32, instruction width in bits.
- `DEPTH`, 1024, number of instruction words; power of two.
- `ISSUE_W`, 2, instructions per fetch group; power of two, ≤ `DEPTH`.
- Derived: `ADDR_W = clog2(DEPTH)`; `SEL_W = clog2(ISSUE_W)`.

- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: a load word is present.
- `load_data` in `DATA_W`: the load word.
- `load_last` in 1: qualifies the final word of the program.
- `load_ready` out 1: the unit accepts a load word this cycle.
- `start` in 1: begin fetching from PC 0.
- `fetch_stall` in 1: decode cannot accept the current group.
- `redirect_valid` in 1: branch redirect request.
- `redirect_pc` in `ADDR_W`: redirect target.
- `fetch_valid` out 1: a group is presented.
- `fetch_pc` out `ADDR_W`: aligned base address of the group.
- `fetch_instr` out `ISSUE_W*DATA_W`: the group; slot i is bits `[i*DATA_W +: DATA_W]`.
- `fetch_slot_valid` out `ISSUE_W`: per-slot valid mask.
- `prog_len` out `ADDR_W+1`: number of words loaded.
- `done` out 1: program exhausted; sticky.

## Operation
- FSM states: LOAD, LOADED, FETCH, DONE. Reset enters LOAD.
- Reset values:
  - `load_ready` = 1.
  - `fetch_valid`, `fetch_pc`, `fetch_instr`, `fetch_slot_valid`, `prog_len`, `done` all 0.
  - Write pointer = 0.
- Memory contents are not cleared by reset; they are undefined until loaded.
- **LOAD:**
  - `load_ready` = 1.
  - When `load_valid && load_ready`: write `mem[wptr] <= load_data` and increment `wptr`.
  - If the accepted word has `load_last` = 1, or `wptr == DEPTH-1`, then `prog_len <= wptr+1` and go to LOADED.
  - `start` is ignored in LOAD.
- **LOADED:**
  - `load_ready` = 0.
  - `start` sets `pc <= 0` and goes to FETCH.
- **FETCH:**
  - `pc` addresses the synchronous-read memory; the group is registered onto the outputs one cycle later.
  - `base = pc` with its low `SEL_W` bits cleared.
  - `fetch_slot_valid[i] = (base+i >= pc) && (base+i < prog_len)`.
  - `fetch_pc = base`.
  - Invalid slots drive 0 on `fetch_instr`.
  - Advance: `pc <= base + ISSUE_W` unless stalled.
  - If `base + ISSUE_W >= prog_len`, this group is the last one. Once it is accepted (`fetch_valid` && !`fetch_stall`), go to DONE.
- **Stall:** while `fetch_valid && fetch_stall`, every fetch output and `pc` hold their values.
- **Redirect:**
  - Accepted in FETCH regardless of stall; it takes priority over both stall and advance.
  - The current group is dropped, and `pc <= redirect_pc`.
  - If `redirect_pc >= prog_len`, go to DONE instead.
- **DONE:**
  - `done` = 1 and `fetch_valid` = 0.
  - `start` restarts at PC 0 in FETCH using the retained program. `done` clears in that cycle.
  - Only `rst` returns the unit to LOAD.
- `prog_len` counts in `ADDR_W+1` bits, so `DEPTH` itself is representable. The address arithmetic never wraps, because `pc` is never advanced past `prog_len`.

## Timing
- Load throughput is 1 word per cycle. The `load_last` word is accepted in cycle t; `load_ready` = 0 and `prog_len` is valid at t+1.
- `start` asserted at cycle t in LOADED or DONE: first group has `fetch_valid` = 1 at t+2.
- Sequential fetch with no stall: a new group every cycle.
- Redirect at cycle t: `fetch_valid` = 0 at t+1 (a bubble), and the target group appears at t+2.
- Stall released at cycle t, i.e. `fetch_stall` = 0 sampled while the group is held: the next group appears at t+1.
- Last group accepted at cycle t: `done` = 1 and `fetch_valid` = 0 at t+1.
- `rst` mid-load or mid-fetch: next cycle shows the full reset state.

## Test plan
- **Load and sequential fetch.** Stimulus: `ISSUE_W`=2; load 5 words (0xA0..0xA4, `load_last` on 0xA4); then `start`. Required:
  - `prog_len` = 5.
  - Groups: `fetch_pc` 0 with mask 11 and data {A1,A0}; `fetch_pc` 2 with mask 11; `fetch_pc` 4 with mask 01 and data {0,A4}.
  - `done` = 1 in the cycle after the group at `fetch_pc` 4 is accepted.
- **Stall.** Stimulus: hold `fetch_stall` for 3 cycles on the group at `fetch_pc` 2. Required: outputs are unchanged for all 3 cycles; the group at `fetch_pc` 4 appears 1 cycle after release.
- **Redirect to odd PC.** Stimulus: `redirect_pc` = 3 while the group at `fetch_pc` 0 is presented and stalled. Required: one bubble, then `fetch_pc` 2 with mask 10 and data {A3,0}.
- **Out-of-range redirect.** Stimulus: `redirect_pc` = 7 with `prog_len` = 5. Required: `done` = 1 at t+1, and no further groups.
- **Full depth.** Stimulus: `DEPTH`=16; stream 16 words without `load_last`. Required:
  - Load stops at word 16, `load_ready` = 0 and `prog_len` = 16.
  - Restart from DONE after a full run yields identical groups.
- **Reset mid-fetch.** Stimulus: assert `rst` during FETCH. Required: next cycle shows state LOAD, `load_ready` = 1, `prog_len` = 0, `fetch_valid` = 0, `done` = 0.
